booth_mul_arbiter: RTL



---
 rtl/booth_mul_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares one multi-cycle signed 8x8 multiplier
// between NREQ requesters, with a timeout guard on the multiplier's ready flag.
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [15:0]       rsp_p,
  output logic              rsp_err,
  output logic              mul_load,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_p,
  input  logic              mul_rdy,
  output logic [1:0]        dbg_state_o
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    a_q, a_d, b_q, b_d;
  logic [15:0]   p_q, p_d;
  logic          err_q, err_d;

  logic          found_hi, found_lo;
  logic [PW-1:0] pick_hi, pick_lo, pick;
  logic [7:0]    sel_a, sel_b;

  // Round robin: lowest valid index at or above ptr, otherwise lowest overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found_hi && req_valid[j] && (PW'(j) >= ptr_q)) begin
        found_hi = 1'b1;
        pick_hi  = PW'(j);
      end
      if (!found_lo && req_valid[j]) begin
        found_lo = 1'b1;
        pick_lo  = PW'(j);
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
    for (int j = 0; j < NREQ; j++) begin
      if (PW'(j) == pick) begin
        sel_a = req_a[8*j +: 8];
        sel_b = req_b[8*j +: 8];
      end
    end
  end

  // Handshake: a request transfers on a clock edge where req_valid[i] and
  // req_ready[i] are both high; req_ready never depends on anything but IDLE
  // state and req_valid, and rsp_valid is a one-cycle pulse with no backpressure.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    timer_d   = timer_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_valid = '0;
    mul_load  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found_lo && !reset) begin
          for (int j = 0; j < NREQ; j++) req_ready[j] = (PW'(j) == pick);
          gnt_d   = pick;
          a_d     = sel_a;
          b_d     = sel_b;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        mul_load = 1'b1;
        timer_d  = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        // The ready flag still reflects the previous operation on the first WAIT cycle.
        if ((timer_q != '0) && mul_rdy) begin
          p_d     = mul_p;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          p_d     = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        for (int j = 0; j < NREQ; j++) rsp_valid[j] = (PW'(j) == gnt_q);
        ptr_d   = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      timer_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      timer_q <= timer_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      err_q   <= err_d;
    end
  end

  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign rsp_p       = p_q;
  assign rsp_err     = err_q;
  assign dbg_state_o = state_q;

endmodule
